// File: rtl/shift_board_ctrl_if.sv
// Board-side signal bundle for shift_board_ctrl: raw switches and buttons in,
// registered shift result and status out.
interface shift_board_ctrl_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] sw;
   logic [5:0]        btn;
   logic [DATA_W-1:0] result;
   logic              carry_out;
   logic              carry_flag;
   logic [7:0]        step_cnt;
   logic [DATA_W-1:0] led;

   modport master (
      output sw, btn,
      input  result, carry_out, carry_flag, step_cnt, led
   );

   modport slave (
      input  sw, btn,
      output result, carry_out, carry_flag, step_cnt, led
   );
endinterface

// File: rtl/shift_board_ctrl.sv
// Board front end (button sync/debounce, operand loading) and ARM-style barrel
// shifter core with carry, registered result and single-step feedback.
module shift_board_ctrl #(
   parameter int DATA_W  = 32,
   parameter int NUM_W   = 8,
   parameter int DEB_CNT = 1000000
) (
   input logic               clk,
   input logic               rst_n,
   shift_board_ctrl_if.slave bus
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam int NB    = 6;

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CNT - 1);
   localparam logic [NUM_W-1:0] N_FULL = NUM_W'(DATA_W);
   localparam logic [SH_W:0]    A_FULL = (SH_W + 1)'(DATA_W);

   logic [NB-1:0]    sync1_q, sync2_q;
   logic [NB-1:0]    deb_q, deb_d;
   logic [CNT_W-1:0] cnt_q [NB];
   logic [CNT_W-1:0] cnt_d [NB];

   logic p_load_q, p_load_d;
   logic p_cfg_q,  p_cfg_d;
   logic p_step_q, p_step_d;
   logic p_clr_q,  p_clr_d;
   logic p_tog_q,  p_tog_d;

   logic [DATA_W-1:0] shift_data_q, shift_data_d;
   logic [NUM_W-1:0]  shift_num_q,  shift_num_d;
   logic [2:0]        shift_op_q,   shift_op_d;
   logic              carry_flag_q, carry_flag_d;
   logic [7:0]        step_cnt_q,   step_cnt_d;
   logic [DATA_W-1:0] result_q,     result_d;
   logic              carry_out_q,  carry_out_d;

   // Counter runs only while the synchronised level disagrees with the accepted one.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_TC) deb_d[i] = sync2_q[i];
            else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      p_load_d = deb_d[0] & ~deb_q[0];
      p_cfg_d  = deb_d[1] & ~deb_q[1];
      p_step_d = deb_d[2] & ~deb_q[2];
      p_clr_d  = deb_d[3] & ~deb_q[3];
      p_tog_d  = deb_d[5] & ~deb_q[5];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
         p_load_q <= 1'b0;
         p_cfg_q  <= 1'b0;
         p_step_q <= 1'b0;
         p_clr_q  <= 1'b0;
         p_tog_q  <= 1'b0;
      end else begin
         sync1_q  <= bus.btn;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
         p_load_q <= p_load_d;
         p_cfg_q  <= p_cfg_d;
         p_step_q <= p_step_d;
         p_clr_q  <= p_clr_d;
         p_tog_q  <= p_tog_d;
      end
   end

   always_comb begin
      shift_data_d = shift_data_q;
      step_cnt_d   = step_cnt_q;
      carry_flag_d = carry_flag_q;
      shift_num_d  = shift_num_q;
      shift_op_d   = shift_op_q;

      if (p_clr_q) begin
         shift_data_d = '0;
         step_cnt_d   = '0;
      end else if (p_load_q) begin
         shift_data_d = bus.sw;
      end else if (p_step_q) begin
         shift_data_d = result_q;
         step_cnt_d   = step_cnt_q + 8'd1;
      end

      if (p_clr_q)       carry_flag_d = 1'b0;
      else if (p_step_q) carry_flag_d = carry_out_q;
      else if (p_tog_q)  carry_flag_d = ~carry_flag_q;

      if (p_cfg_q) {shift_num_d, shift_op_d} = bus.sw[DATA_W-1 -: NUM_W+3];
   end

   logic [SH_W-1:0]          ni;
   logic                     n_zero, n_in;
   logic [SH_W:0]            amt;
   logic [DATA_W:0]          lsl_w, lsr_w;
   logic signed [DATA_W:0]   asr_w;
   logic [2*DATA_W-1:0]      ror_w;

   // Shifts run one bit wider than the data so the carry falls out of the
   // extra bit, including the full-width (amount = DATA_W) cases.
   always_comb begin
      ni          = shift_num_q[SH_W-1:0];
      n_zero      = (shift_num_q == '0);
      n_in        = (shift_num_q <= N_FULL);
      amt         = '0;
      lsl_w       = '0;
      lsr_w       = '0;
      asr_w       = '0;
      ror_w       = '0;
      result_d    = shift_data_q;
      carry_out_d = carry_flag_q;

      case (shift_op_q)
         3'b000: begin
            if (ni != '0) begin
               lsl_w       = {1'b0, shift_data_q} << ni;
               result_d    = lsl_w[DATA_W-1:0];
               carry_out_d = lsl_w[DATA_W];
            end
         end
         3'b001: begin
            if (!n_zero) begin
               if (n_in) begin
                  lsl_w       = {1'b0, shift_data_q} << shift_num_q[SH_W:0];
                  result_d    = lsl_w[DATA_W-1:0];
                  carry_out_d = lsl_w[DATA_W];
               end else begin
                  result_d    = '0;
                  carry_out_d = 1'b0;
               end
            end
         end
         3'b010: begin
            amt         = (ni == '0) ? A_FULL : {1'b0, ni};
            lsr_w       = {shift_data_q, 1'b0} >> amt;
            result_d    = lsr_w[DATA_W:1];
            carry_out_d = lsr_w[0];
         end
         3'b011: begin
            if (!n_zero) begin
               if (n_in) begin
                  lsr_w       = {shift_data_q, 1'b0} >> shift_num_q[SH_W:0];
                  result_d    = lsr_w[DATA_W:1];
                  carry_out_d = lsr_w[0];
               end else begin
                  result_d    = '0;
                  carry_out_d = 1'b0;
               end
            end
         end
         3'b100: begin
            amt         = (ni == '0) ? A_FULL : {1'b0, ni};
            asr_w       = $signed({shift_data_q, 1'b0}) >>> amt;
            result_d    = asr_w[DATA_W:1];
            carry_out_d = asr_w[0];
         end
         3'b101: begin
            if (!n_zero) begin
               amt         = n_in ? shift_num_q[SH_W:0] : A_FULL;
               asr_w       = $signed({shift_data_q, 1'b0}) >>> amt;
               result_d    = asr_w[DATA_W:1];
               carry_out_d = asr_w[0];
            end
         end
         3'b110: begin
            if (ni == '0) begin
               result_d    = {carry_flag_q, shift_data_q[DATA_W-1:1]};
               carry_out_d = shift_data_q[0];
            end else begin
               ror_w       = {shift_data_q, shift_data_q} >> ni;
               result_d    = ror_w[DATA_W-1:0];
               carry_out_d = ror_w[DATA_W-1];
            end
         end
         default: begin
            if (!n_zero) begin
               if (ni == '0) begin
                  carry_out_d = shift_data_q[DATA_W-1];
               end else begin
                  ror_w       = {shift_data_q, shift_data_q} >> ni;
                  result_d    = ror_w[DATA_W-1:0];
                  carry_out_d = ror_w[DATA_W-1];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_data_q <= '0;
         shift_num_q  <= '0;
         shift_op_q   <= '0;
         carry_flag_q <= 1'b0;
         step_cnt_q   <= '0;
         result_q     <= '0;
         carry_out_q  <= 1'b0;
      end else begin
         shift_data_q <= shift_data_d;
         shift_num_q  <= shift_num_d;
         shift_op_q   <= shift_op_d;
         carry_flag_q <= carry_flag_d;
         step_cnt_q   <= step_cnt_d;
         result_q     <= result_d;
         carry_out_q  <= carry_out_d;
      end
   end

   assign bus.result     = result_q;
   assign bus.carry_out  = carry_out_q;
   assign bus.carry_flag = carry_flag_q;
   assign bus.step_cnt   = step_cnt_q;
   assign bus.led        = {carry_out_q, {(DATA_W-2){1'b0}}, carry_flag_q};

endmodule

// File: tb/tb_shift_board_ctrl.sv
// Directed bench for shift_board_ctrl: a spec-level model is compared against the
// DUT outputs every cycle, plus hand-computed checkpoints after each scenario.
module tb_shift_board_ctrl;
   localparam int DW  = 32;
   localparam int NW  = 8;
   localparam int DEB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   shift_board_ctrl_if #(.DATA_W(DW)) bus ();

   shift_board_ctrl #(.DATA_W(DW), .NUM_W(NW), .DEB_CNT(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_data, m_result;
   int          m_num, m_op, m_cnt;
   bit          m_c, m_cout;
   bit [5:0]    m_deb, m_p;
   bit [5:0]    hist [DEB+1];

   function automatic void mshift(input logic [31:0] d, input int n, input int op, input bit c,
                                  output logic [31:0] r, output bit co);
      int ni;
      ni = n % 32;
      r  = d;
      co = c;
      case (op)
         0: if (ni != 0) begin r = d << ni; co = d[32-ni]; end
         1: if (n != 0) begin
               if (n < 32)       begin r = d << n; co = d[32-n]; end
               else if (n == 32) begin r = 0; co = d[0]; end
               else              begin r = 0; co = 0; end
            end
         2: if (ni == 0) begin r = 0; co = d[31]; end
            else begin r = d >> ni; co = d[ni-1]; end
         3: if (n != 0) begin
               if (n < 32)       begin r = d >> n; co = d[n-1]; end
               else if (n == 32) begin r = 0; co = d[31]; end
               else              begin r = 0; co = 0; end
            end
         4: if (ni == 0) begin r = {32{d[31]}}; co = d[31]; end
            else begin r = 32'($signed(d) >>> ni); co = d[ni-1]; end
         5: if (n != 0) begin
               if (n < 32) begin r = 32'($signed(d) >>> n); co = d[n-1]; end
               else        begin r = {32{d[31]}}; co = d[31]; end
            end
         6: if (ni == 0) begin r = {c, d[31:1]}; co = d[0]; end
            else begin r = (d >> ni) | (d << (32 - ni)); co = d[ni-1]; end
         default:
            if (n != 0) begin
               if (ni == 0) co = d[31];
               else begin r = (d >> ni) | (d << (32 - ni)); co = r[31]; end
            end
      endcase
   endfunction

   task automatic model_reset();
      m_data = 0; m_result = 0; m_num = 0; m_op = 0; m_cnt = 0;
      m_c = 0; m_cout = 0; m_deb = 0; m_p = 0;
      for (int j = 0; j <= DEB; j++) hist[j] = 0;
   endtask

   // Advance the model across the next rising edge, using the inputs the DUT will sample.
   task automatic model_step();
      logic [31:0] nr;
      bit          nco;
      bit [5:0]    newp;
      bit          diff;
      mshift(m_data, m_num, m_op, m_c, nr, nco);
      if (m_p[3])      begin m_data = 0; m_cnt = 0; end
      else if (m_p[0]) m_data = bus.sw;
      else if (m_p[2]) begin m_data = m_result; m_cnt = (m_cnt + 1) % 256; end
      if (m_p[3])      m_c = 0;
      else if (m_p[2]) m_c = m_cout;
      else if (m_p[5]) m_c = !m_c;
      if (m_p[1]) begin m_num = int'(bus.sw[31:24]); m_op = int'(bus.sw[23:21]); end
      m_result = nr;
      m_cout   = nco;
      newp = 0;
      for (int i = 0; i < 6; i++) begin
         diff = 1;
         for (int j = 1; j <= DEB; j++) if (hist[j][i] == m_deb[i]) diff = 0;
         if (diff) begin
            newp[i]  = !m_deb[i];
            m_deb[i] = !m_deb[i];
         end
      end
      m_p = newp;
      for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = bus.btn;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      cmp("result",     bus.result, m_result);
      cmp("carry_out",  {31'b0, bus.carry_out}, {31'b0, m_cout});
      cmp("carry_flag", {31'b0, bus.carry_flag}, {31'b0, m_c});
      cmp("step_cnt",   {24'b0, bus.step_cnt}, 32'(m_cnt));
      cmp("led",        bus.led, {m_cout, 30'b0, m_c});
      if (rst_n) model_step();
   end

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp || mdl !== exp) begin
         n_bad++;
         $display("FAIL lit %s: dut %h model %h required %h", nm, act, mdl, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      bus.btn[b] = 1'b1;
      tick(8);
      bus.btn[b] = 1'b0;
      tick(10);
   endtask

   function automatic logic [31:0] cfg(input int n, input int op);
      return {8'(n), 3'(op), 21'b0};
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nlist [7] = '{0, 1, 5, 31, 32, 33, 255};
      bus.sw  = '0;
      bus.btn = '0;
      tick(3);
      lit("reset_result", bus.result, m_result, 32'h0);
      lit("reset_led",    bus.led,    {m_cout, 30'b0, m_c}, 32'h0);
      rst_n = 1'b1;
      tick(2);

      // LSL imm by 1
      bus.sw = 32'h8000_0001; press(0);
      bus.sw = cfg(1, 0);     press(1);
      lit("lsl_result", bus.result, m_result, 32'h0000_0002);
      lit("lsl_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);
      lit("lsl_led",    bus.led, {m_cout, 30'b0, m_c}, 32'h8000_0000);

      // LSR imm n=0 (shift by 32), then LSR reg n=0 (pass through with carry)
      press(3);
      bus.sw = 32'h8000_0000; press(0);
      bus.sw = cfg(0, 2);     press(1);
      lit("lsr32_result", bus.result, m_result, 32'h0);
      lit("lsr32_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);
      press(5);
      lit("toggle_cflag", {31'b0, bus.carry_flag}, {31'b0, m_c}, 32'h1);
      bus.sw = cfg(0, 3); press(1);
      lit("lsrreg0_result", bus.result, m_result, 32'h8000_0000);
      lit("lsrreg0_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);

      // ASR reg beyond width, ROR reg by a multiple of the width
      bus.sw = cfg(40, 5); press(1);
      lit("asr40_result", bus.result, m_result, 32'hFFFF_FFFF);
      lit("asr40_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);
      bus.sw = cfg(32, 7); press(1);
      lit("ror32_result", bus.result, m_result, 32'h8000_0000);
      lit("ror32_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);

      // RRX step chain
      press(3);
      bus.sw = 32'h0000_0003; press(0);
      bus.sw = cfg(0, 6);     press(1);
      lit("rrx0_result", bus.result, m_result, 32'h0000_0001);
      lit("rrx0_cout",   {31'b0, bus.carry_out}, {31'b0, m_cout}, 32'h1);
      press(2);
      lit("rrx1_cflag",  {31'b0, bus.carry_flag}, {31'b0, m_c}, 32'h1);
      lit("rrx1_result", bus.result, m_result, 32'h8000_0000);
      press(2);
      lit("rrx2_cflag",  {31'b0, bus.carry_flag}, {31'b0, m_c}, 32'h1);
      lit("rrx2_result", bus.result, m_result, 32'hC000_0000);
      press(2);
      lit("rrx3_cflag",  {31'b0, bus.carry_flag}, {31'b0, m_c}, 32'h0);
      lit("rrx3_result", bus.result, m_result, 32'h6000_0000);
      lit("rrx3_steps",  {24'b0, bus.step_cnt}, 32'(m_cnt), 32'd3);

      // Debounce: glitch, long hold, clear beats load
      bus.sw = cfg(0, 0); press(1);
      press(3);
      bus.sw = 32'h1234_5678;
      bus.btn[0] = 1'b1; tick(3); bus.btn[0] = 1'b0; tick(12);
      lit("glitch_result", bus.result, m_result, 32'h0);
      bus.btn[0] = 1'b1; tick(10);
      bus.sw = 32'hFFFF_FFFF; tick(10);
      bus.btn[0] = 1'b0; tick(10);
      lit("hold_result", bus.result, m_result, 32'h1234_5678);
      bus.btn = 6'b001001; tick(8);
      bus.btn = 6'b000000; tick(10);
      lit("clr_vs_load", bus.result, m_result, 32'h0);

      // Async reset in the middle of a press
      bus.sw = 32'h1234_5678; press(0);
      press(5);
      bus.btn[0] = 1'b1; tick(3);
      rst_n = 1'b0; #2;
      cmp("rst_result", bus.result, 32'h0);
      cmp("rst_cflag",  {31'b0, bus.carry_flag}, 32'h0);
      cmp("rst_led",    bus.led, 32'h0);
      tick(2);
      bus.btn[0] = 1'b0;
      rst_n = 1'b1;
      tick(15);
      lit("post_rst_result", bus.result, m_result, 32'h0);

      // Sweep of all encodings over boundary amounts, checked by the model each cycle
      bus.sw = 32'hA5C3_0F81; press(0);
      press(5);
      for (int op = 0; op < 8; op++) begin
         for (int k = 0; k < 7; k++) begin
            bus.sw = cfg(nlist[k], op);
            press(1);
         end
      end

      // step_cnt wrap
      press(3);
      bus.sw = cfg(0, 0); press(1);
      for (int s = 0; s < 255; s++) press(2);
      lit("steps_255", {24'b0, bus.step_cnt}, 32'(m_cnt), 32'd255);
      press(2);
      lit("steps_wrap", {24'b0, bus.step_cnt}, 32'(m_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/shift_board_ctrl.md
# shift_board_ctrl

Parametrised board-level front end and execution core for the ARM-style barrel shifter. It debounces the raw push-buttons and loads the operand and control registers from the switches. It evaluates all eight ARM shift encodings, with carry, into registered outputs for the LEDs and the seven-segment display driver. A step mode feeds the result back as the next operand, so iterated shifts can be walked on the board one button press at a time.

## Interface
Parameters:
- DATA_W, 32: operand width. Must be a power of two and ≥ 8. SH_W = log2(DATA_W).
- NUM_W, 8: shift-amount register width, ≥ SH_W+1.
- DEB_CNT, 1000000: number of cycles a synchronised button must hold a level before that level is accepted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- sw  in  DATA_W  raw switches. sw[DATA_W-1] is the leftmost switch.
- btn  in  6  raw buttons, active-high, asynchronous to clk.
- result  out  DATA_W  registered shift result, to the display driver.
- carry_out  out  1  registered shifter carry.
- carry_flag  out  1  current carry-in flag.
- step_cnt  out  8  count of executed steps; wraps from 255 to 0.
- led  out  DATA_W  led[DATA_W-1]=carry_out, led[0]=carry_flag, all other bits 0.

## Operation
Button front end:
- Each btn bit passes through a 2-FF synchroniser and a per-button debounce counter.
- The debounced level updates only after the synchronised input differs from it for DEB_CNT consecutive cycles.
- A debounced 0→1 transition produces a one-cycle pulse p[i].

Button pulse actions:
- p0: shift_data ← sw.
- p1: {shift_num, shift_op} ← sw[DATA_W-1 -: NUM_W+3]. shift_num is the top NUM_W bits; shift_op is the next 3 bits.
- p2 (step): shift_data ← result, carry_flag ← carry_out, step_cnt ← step_cnt+1.
- p3 (clear): shift_data, step_cnt and carry_flag ← 0. shift_num and shift_op are unchanged.
- p5: carry_flag ← ~carry_flag.
- btn[4] is reserved and ignored.
- Priority within one cycle: p3 > p0 > p2 for shift_data and step_cnt; for carry_flag, p3 > p2 > p5. p1 acts independently of the others.

Shift rules, with D = shift_data, n = shift_num, ni = n[SH_W-1:0], c = carry_flag:
- 000 LSL imm: ni=0 gives D, c. Otherwise D<<ni, carry D[DATA_W-ni].
- 001 LSL reg: n=0 gives D, c. 1..DATA_W-1 gives D<<n, carry D[DATA_W-n]. n=DATA_W gives 0, carry D[0]. n>DATA_W gives 0, carry 0.
- 010 LSR imm: ni=0 means a shift by DATA_W and gives 0, carry D[DATA_W-1]. Otherwise D>>ni, carry D[ni-1].
- 011 LSR reg: n=0 gives D, c. 1..DATA_W-1 gives D>>n, carry D[n-1]. n=DATA_W gives 0, carry D[DATA_W-1]. n>DATA_W gives 0, carry 0.
- 100 ASR imm: ni=0 gives all bits equal to D[DATA_W-1], carry D[DATA_W-1]. Otherwise arithmetic shift right by ni, carry D[ni-1].
- 101 ASR reg: n=0 gives D, c. 1..DATA_W-1 gives an arithmetic shift, carry D[n-1]. n≥DATA_W gives all bits equal to sign, carry sign.
- 110 ROR imm: ni=0 is RRX and gives {c, D[DATA_W-1:1]}, carry D[0]. Otherwise rotate right by ni, carry D[ni-1].
- 111 ROR reg: n=0 gives D, c. If n≠0 and ni=0, gives D, carry D[DATA_W-1]. Otherwise rotate right by ni, carry = the result's MSB.
- All shift arithmetic is unsigned on n. Bit widths never truncate n before the comparisons above.

## Timing
- Reset values: shift_data, shift_num, shift_op, carry_flag, step_cnt, result, carry_out and led are all 0. Debounced levels and debounce counters are also 0.
- Button latency: a clean press produces its pulse 2 + DEB_CNT cycles after the raw edge, ±1 cycle.
- A glitch shorter than DEB_CNT cycles produces no pulse. A held button produces exactly one pulse; release produces none.
- result and carry_out are registered. They reflect the register state of the previous cycle, so a load at edge k is visible at edge k+1.
- Step reads the result registered in the cycle of the pulse, which already reflects the current operands. Two steps are therefore never merged.
- step_cnt wraps from 255 to 0 with no other effect.
- If rst_n asserts mid-debounce, the press is discarded. After release the outputs stay 0 until new pulses arrive.

## Test plan
Benches use DEB_CNT=4 and DATA_W=32.
- Load and LSL imm: load data 0x8000_0001, then n=1 with op 000. Required: result=0x0000_0002, carry_out=1, led[31]=1.
- LSR imm with n=0: data 0x8000_0000. Required: result=0, carry_out=1. Then LSR reg with n=0 and carry_flag=1. Required: result=0x8000_0000, carry_out=1 (carry passes through unchanged).
- ASR reg with n=40 on 0x8000_0000. Required: result=0xFFFF_FFFF, carry_out=1. ROR reg with n=32 on 0x8000_0000. Required: result unchanged, carry_out=1.
- RRX step chain: data 0x0000_0003, carry_flag=0, op 110 with n=0, three step presses. Required sequence: 0x0000_0001 (c=1), 0x8000_0000 (c=1), 0xC000_0000 (c=0). step_cnt=3.
- Debounce: a 3-cycle glitch on btn[0] gives no load. Holding btn[0] for 20 cycles gives exactly one load. Pressing btn[3] and btn[0] in the same cycle leaves shift_data=0.
- Async reset asserted mid-press clears every output within the same cycle. Releasing reset without a press leaves result=0.
